// File: rtl/datamem_ctrl.sv
// Synchronous byte-addressed data memory for the MEM stage.
// Supports byte/half/word lanes, a req/ack handshake with wait states, and fault reporting.
module datamem_ctrl #(
    parameter int unsigned AWIDTH       = 32,
    parameter int unsigned DEPTH        = 128,
    parameter int unsigned WAIT_CYCLES  = 1,
    parameter int unsigned PROTECT_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [AWIDTH-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              ack,
    output logic [31:0]       rdata,
    output logic              fault
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned LW = IW + 2;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [LW-1:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        bad_q, bad_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;

    logic [31:0] mem [DEPTH];

    logic          idle, req_bad, go_resp, mem_we;
    logic          cur_we, cur_sign, cur_bad;
    logic [1:0]    cur_size;
    logic [LW-1:0] cur_addr;
    logic [IW-1:0] cur_idx;
    logic [31:0]   cur_wdata, word, rd_val, wr_lanes;
    logic [15:0]   shifted;
    logic [3:0]    be;

    assign idle = (state_q == StIdle);

    always_comb begin
        req_bad = 1'b0;
        case (size)
            2'b00:   req_bad = 1'b0;
            2'b01:   req_bad = addr[0];
            2'b10:   req_bad = |addr[1:0];
            default: req_bad = 1'b1;
        endcase
        if ((addr >> LW) != '0) req_bad = 1'b1;
    end

    // With zero wait states the commit edge is the acceptance edge, so use the live inputs.
    assign cur_we    = idle ? we : we_q;
    assign cur_size  = idle ? size : size_q;
    assign cur_sign  = idle ? sign_ext : sign_q;
    assign cur_addr  = idle ? addr[LW-1:0] : addr_q;
    assign cur_wdata = idle ? wdata : wdata_q;
    assign cur_bad   = idle ? req_bad : bad_q;
    assign cur_idx   = cur_addr[LW-1:2];

    always_comb begin
        word = mem[cur_idx];
        if (PROTECT_ZERO != 0 && cur_idx == '0) word = '0;
        shifted = 16'(word >> {cur_addr[1:0], 3'b000});
        case (cur_size)
            2'b00:   rd_val = {{24{cur_sign & shifted[7]}}, shifted[7:0]};
            2'b01:   rd_val = {{16{cur_sign & shifted[15]}}, shifted[15:0]};
            default: rd_val = word;
        endcase
    end

    always_comb begin
        case (cur_size)
            2'b00: begin
                wr_lanes = {4{cur_wdata[7:0]}};
                be       = 4'b0001 << cur_addr[1:0];
            end
            2'b01: begin
                wr_lanes = {2{cur_wdata[15:0]}};
                be       = cur_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_lanes = cur_wdata;
                be       = 4'b1111;
            end
        endcase
        if (PROTECT_ZERO != 0 && cur_idx == '0) be = 4'b0000;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        sign_d  = sign_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        bad_d   = bad_q;
        go_resp = 1'b0;
        case (state_q)
            StIdle: begin
                if (req) begin
                    we_d    = we;
                    size_d  = size;
                    sign_d  = sign_ext;
                    addr_d  = addr[LW-1:0];
                    wdata_d = wdata;
                    bad_d   = req_bad;
                    if (WAIT_CYCLES == 0) begin
                        state_d = StResp;
                        go_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 3'(WAIT_CYCLES);
                    end
                end
            end
            StWait: begin
                if (cnt_q <= 3'd1) begin
                    state_d = StResp;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        rdata_d = '0;
        fault_d = 1'b0;
        mem_we  = 1'b0;
        if (go_resp) begin
            fault_d = cur_bad;
            if (!cur_bad) begin
                if (cur_we) mem_we = 1'b1;
                else        rdata_d = rd_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            sign_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            bad_q   <= 1'b0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            bad_q   <= bad_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // Array is never reset; reset only suppresses the commit.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[cur_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
            end
        end
    end

    assign ready = idle && rst_n;
    assign ack   = (state_q == StResp);
    assign rdata = rdata_q;
    assign fault = fault_q;
endmodule

// File: tb/tb_datamem_ctrl.sv
// Bench for datamem_ctrl: four instances (1, 0, 3, 7 wait states) against a byte-array model.
module tb_datamem_ctrl;
    logic        clk = 1'b0;
    logic [3:0]  rst_nv;
    logic [3:0]  req_v;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ready_v, ack_v, fault_v;
    logic [31:0] rdata_v [4];

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] mdl [4][512];

    always #5 clk = ~clk;

    function automatic int wait_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 3 : 7;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned W = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 7;
        datamem_ctrl #(
            .AWIDTH(32), .DEPTH(128), .WAIT_CYCLES(W), .PROTECT_ZERO(1)
        ) u_dut (
            .clk(clk), .rst_n(rst_nv[g]), .req(req_v[g]), .we(we), .size(size),
            .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .ready(ready_v[g]),
            .ack(ack_v[g]), .rdata(rdata_v[g]), .fault(fault_v[g])
        );
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction on instance d, checking handshake timing and result.
    task automatic do_txn(input int d, input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
        int wt = wait_of(d);
        int nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        logic exp_f;
        logic [31:0] exp_r = '0;
        exp_f = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
                || (a >= 32'd512);
        if (!exp_f && !w) begin
            for (int b = nb - 1; b >= 0; b--) exp_r = (exp_r << 8) | {24'h0, mdl[d][int'(a) + b]};
            if (sx && nb < 4 && exp_r[8*nb-1]) exp_r = exp_r | (32'hFFFF_FFFF << (8 * nb));
        end
        @(negedge clk);
        we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        req_v[d] = 1'b1;
        chk1("ready_pre", ready_v[d], 1'b1);
        @(posedge clk); #1;
        req_v[d] = 1'b0;
        for (int k = 1; k <= wt + 1; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            chk1("ready_busy", ready_v[d], 1'b0);
            chk1("ack_latency", ack_v[d], k == wt + 1);
        end
        got = rdata_v[d];
        chk1("fault", fault_v[d], exp_f);
        chk32("rdata", rdata_v[d], exp_r);
        if (w && !exp_f && a >= 32'd4) begin
            for (int b = 0; b < nb; b++) mdl[d][int'(a) + b] = wd[8*b +: 8];
        end
        @(posedge clk); #1;
        chk1("ready_after", ready_v[d], 1'b1);
        chk1("ack_drop", ack_v[d], 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] got;
        int wt;
        rst_nv = '0; req_v = '0; we = 0; size = 0; sign_ext = 0; addr = 0; wdata = 0;
        for (int d = 0; d < 4; d++) for (int i = 0; i < 512; i++) mdl[d][i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            chk1("rst_ready", ready_v[d], 1'b0);
            chk1("rst_ack", ack_v[d], 1'b0);
            chk1("rst_fault", fault_v[d], 1'b0);
            chk32("rst_rdata", rdata_v[d], 32'h0);
        end
        @(negedge clk);
        rst_nv = '1;
        #1;
        for (int d = 0; d < 4; d++) chk1("ready_release", ready_v[d], 1'b1);

        for (int d = 0; d < 4; d++)
            for (int i = 1; i < 128; i++) do_txn(d, 1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, got);

        // Directed word/lane scenarios on the single-wait-state instance.
        do_txn(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, got);
        do_txn(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, got);
        chk32("tp_word", got, 32'hDEADBEEF);
        do_txn(0, 1'b1, 2'd0, 1'b0, 32'h12, 32'h55, got);
        do_txn(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, got);
        chk32("tp_byte_merge", got, 32'hDE55BEEF);
        do_txn(0, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, got);
        chk32("tp_sbyte", got, 32'hFFFFFFDE);
        do_txn(0, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, got);
        chk32("tp_uhalf", got, 32'h0000DE55);
        do_txn(0, 1'b0, 2'd1, 1'b1, 32'h10, 32'h0, got);
        chk32("tp_shalf", got, 32'hFFFFBEEF);

        do_txn(0, 1'b1, 2'd2, 1'b0, 32'h04, 32'h01020304, got);
        do_txn(0, 1'b1, 2'd2, 1'b0, 32'h06, 32'hCAFEF00D, got);
        do_txn(0, 1'b1, 2'd1, 1'b0, 32'h11, 32'hCAFEF00D, got);
        do_txn(0, 1'b1, 2'd3, 1'b0, 32'h04, 32'hCAFEF00D, got);
        do_txn(0, 1'b1, 2'd2, 1'b0, 32'h200, 32'hCAFEF00D, got);
        do_txn(0, 1'b0, 2'd2, 1'b0, 32'h04, 32'h0, got);
        chk32("tp_fault_untouched", got, 32'h01020304);
        do_txn(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, got);
        chk32("tp_fault_untouched2", got, 32'hDE55BEEF);

        do_txn(0, 1'b1, 2'd2, 1'b0, 32'h0, 32'h12345678, got);
        do_txn(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, got);
        chk32("tp_zero_word", got, 32'h0);
        do_txn(0, 1'b0, 2'd0, 1'b1, 32'h3, 32'h0, got);
        chk32("tp_zero_byte", got, 32'h0);

        // Throughput with req held high continuously.
        for (int d = 1; d < 4; d++) begin
            wt = wait_of(d);
            @(negedge clk);
            we = 1'b0; size = 2'd2; sign_ext = 1'b0; addr = 32'h40; req_v[d] = 1'b1;
            for (int s = 0; s < 3 * (2 + wt); s++) begin
                @(posedge clk); #1;
                chk1("tput_ack", ack_v[d], (s + 2) % (wt + 2) == 0);
                chk1("tput_ready", ready_v[d], (s + 1) % (wt + 2) == 0);
                if ((s + 2) % (wt + 2) == 0)
                    chk32("tput_rdata", rdata_v[d],
                          {mdl[d][67], mdl[d][66], mdl[d][65], mdl[d][64]});
            end
            req_v[d] = 1'b0;
        end

        // Reset while a write to 0x20 is waiting: write must be lost, no ack.
        do_txn(2, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11111111, got);
        @(negedge clk);
        we = 1'b1; size = 2'd2; sign_ext = 1'b0; addr = 32'h20; wdata = 32'hA5A5A5A5;
        req_v[2] = 1'b1;
        @(posedge clk); #1;
        req_v[2] = 1'b0;
        chk1("abort_ack0", ack_v[2], 1'b0);
        @(posedge clk); #1;
        rst_nv[2] = 1'b0;
        #1;
        chk1("abort_ready_rst", ready_v[2], 1'b0);
        @(posedge clk); #1;
        rst_nv[2] = 1'b1;
        #1;
        chk1("abort_ready_release", ready_v[2], 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk1("abort_no_ack", ack_v[2], 1'b0);
        end
        do_txn(2, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, got);
        chk32("abort_mem", got, 32'h11111111);

        for (int i = 0; i < 80; i++) begin
            int d = int'($urandom_range(0, 3));
            logic [1:0] sz = 2'($urandom_range(0, 3));
            logic [31:0] a = 32'($urandom_range(0, 32'h21F));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd2) a[1:0] = 2'b00;
                if (sz == 2'd1) a[0] = 1'b0;
            end
            do_txn(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, got);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
